// File: rtl/wi23_defs.sv
// Shared definitions for the WI23 memory-mapped peripherals (timer register map).
package wi23_defs;

    // Word offsets inside the timer window
    typedef enum logic [1:0] {
        TMR_CTRL  = 2'd0,
        TMR_PRESC = 2'd1,
        TMR_COUNT = 2'd2,
        TMR_CMP   = 2'd3
    } timer_reg_t;

    // CTRL register bit positions
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_MATCH      = 8;
    localparam int CTRL_OVF        = 9;

    // Base address used by the top-level memory map decoder
    localparam logic [15:0] TIMER_BASE = 16'hC010;

    // Replace the enabled bytes of a word with the corresponding bytes of new data
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  byteEn);
        logic [31:0] result;
        result = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
                result[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Timer prescaler: holds the PRESCALE reload value, the prescale counter and
// produces the terminal-count strobe plus its registered tick pulse.
module timer_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     prescWr_i,
    input  logic [PRESC_WIDTH/8-1:0] we_i,
    input  logic [PRESC_WIDTH-1:0]   wdata_i,
    output logic [PRESC_WIDTH-1:0]   reload_o,
    output logic                     terminal_o,
    output logic                     tick_o
);

    localparam logic [PRESC_WIDTH-1:0] PCNT_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESC_WIDTH-1:0] reload_q, reload_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                   tick_q;
    logic                   terminal;

    assign terminal   = en_i & (pcnt_q == reload_q);
    assign terminal_o = terminal;
    assign reload_o   = reload_q;
    assign tick_o     = tick_q;

    // Next reload value and prescale count; a PRESCALE write restarts the period
    always_comb begin
        reload_d = reload_q;
        if (prescWr_i) begin
            for (int i = 0; i < PRESC_WIDTH/8; i++) begin
                if (we_i[i]) begin
                    reload_d[8*i +: 8] = wdata_i[8*i +: 8];
                end
            end
        end
        if (prescWr_i || terminal) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Prescaler state; tick is the terminal strobe delayed by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
            pcnt_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            pcnt_q   <= pcnt_d;
            tick_q   <= terminal;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral: CTRL/PRESCALE/COUNT/COMPARE registers,
// compare-match and overflow flags, level interrupt and prescaled tick pulse.
module mmio_timer
    import wi23_defs::*;
#(
    parameter int PRESC_WIDTH = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic [1:0]  addr_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  re_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic        tick_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    timer_reg_t regSel;

    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   compare_q, compare_d;
    logic                   en_q, en_d;
    logic                   autoReload_q, autoReload_d;
    logic                   irqEn_q, irqEn_d;
    logic                   match_q, match_d;
    logic                   ovf_q, ovf_d;

    logic                   wrAny, wrCtrl, wrPresc, wrCount, wrCmp;
    logic                   terminal;
    logic [PRESC_WIDTH-1:0] reload;
    logic                   isMatch, isMax, matchSet, ovfSet;
    logic                   matchClr, ovfClr;
    logic [CNT_WIDTH-1:0]   countTick;

    assign regSel  = timer_reg_t'(addr_i);
    assign wrAny   = sel_i & (|we_i);
    assign wrCtrl  = wrAny & (regSel == TMR_CTRL);
    assign wrPresc = wrAny & (regSel == TMR_PRESC);
    assign wrCount = wrAny & (regSel == TMR_COUNT);
    assign wrCmp   = wrAny & (regSel == TMR_CMP);

    timer_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_q),
        .prescWr_i (wrPresc),
        .we_i      (we_i[PRESC_WIDTH/8-1:0]),
        .wdata_i   (wdata_i[PRESC_WIDTH-1:0]),
        .reload_o  (reload),
        .terminal_o(terminal),
        .tick_o    (tick_o)
    );

    // On a tick, a match takes priority; an all-ones count that is not an
    // auto-reloading match wraps and flags overflow.
    assign isMatch   = (count_q == compare_q);
    assign isMax     = &count_q;
    assign matchSet  = terminal & isMatch;
    assign ovfSet    = terminal & isMax & ~(isMatch & autoReload_q);
    assign countTick = (isMatch & autoReload_q) ? '0 : count_q + CNT_ONE;
    assign matchClr  = wrCtrl & we_i[1] & wdata_i[CTRL_MATCH];
    assign ovfClr    = wrCtrl & we_i[1] & wdata_i[CTRL_OVF];

    assign irq_o = irqEn_q & (match_q | ovf_q);

    // Register-file next state: software COUNT writes beat the tick update, flag sets beat clears
    always_comb begin
        en_d         = en_q;
        autoReload_d = autoReload_q;
        irqEn_d      = irqEn_q;
        compare_d    = compare_q;
        count_d      = count_q;
        if (wrCtrl && we_i[0]) begin
            en_d         = wdata_i[CTRL_EN];
            autoReload_d = wdata_i[CTRL_AUTORELOAD];
            irqEn_d      = wdata_i[CTRL_IRQ_EN];
        end
        if (wrCmp) begin
            compare_d = mergeBytes(compare_q, wdata_i, we_i);
        end
        if (wrCount) begin
            count_d = mergeBytes(count_q, wdata_i, we_i);
        end else if (terminal) begin
            count_d = countTick;
        end
        match_d = (match_q & ~matchClr) | matchSet;
        ovf_d   = (ovf_q & ~ovfClr) | ovfSet;
    end

    // Register file storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            compare_q    <= '0;
            en_q         <= 1'b0;
            autoReload_q <= 1'b0;
            irqEn_q      <= 1'b0;
            match_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            en_q         <= en_d;
            autoReload_q <= autoReload_d;
            irqEn_q      <= irqEn_d;
            match_q      <= match_d;
            ovf_q        <= ovf_d;
        end
    end

    // Combinational read mux; returns pre-write values during a same-cycle write
    always_comb begin
        rdata_o = '0;
        if (sel_i && (|re_i)) begin
            case (regSel)
                TMR_CTRL: begin
                    rdata_o[CTRL_EN]         = en_q;
                    rdata_o[CTRL_AUTORELOAD] = autoReload_q;
                    rdata_o[CTRL_IRQ_EN]     = irqEn_q;
                    rdata_o[CTRL_MATCH]      = match_q;
                    rdata_o[CTRL_OVF]        = ovf_q;
                end
                TMR_PRESC: rdata_o[PRESC_WIDTH-1:0] = reload;
                TMR_COUNT: rdata_o = count_q;
                TMR_CMP:   rdata_o = compare_q;
                default:   rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus a randomized
// bus run, all checked against a behavioural model of the timer.
module tb_mmio_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  we = 4'd0;
    logic [3:0]  re = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic        tick;

    int totalChecks = 0;
    int badChecks   = 0;

    // Behavioural model state, kept as plain numbers
    int unsigned mCount, mCmp, mPresc, mPcnt;
    bit mEn, mAr, mIe, mMatch, mOvf, mTick;

    logic [31:0] lastRdata;
    logic        lastIrq, lastTick;

    always #5 clk = ~clk;

    mmio_timer dut (
        .clk    (clk),
        .rst    (rst),
        .sel_i  (sel),
        .addr_i (addr),
        .we_i   (we),
        .re_i   (re),
        .wdata_i(wdata),
        .rdata_o(rdata),
        .irq_o  (irq),
        .tick_o (tick)
    );

    // Hard stop in case something never returns
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned byteMerge(input int unsigned oldV, input int unsigned newV,
                                              input logic [3:0] en);
        int unsigned mask;
        mask = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) mask = mask | (32'hFF << (8*i));
        end
        return (oldV & ~mask) | (newV & mask);
    endfunction

    function automatic int unsigned modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return (mOvf ? 32'h200 : 0) + (mMatch ? 32'h100 : 0) +
                            (mIe ? 4 : 0) + (mAr ? 2 : 0) + (mEn ? 1 : 0);
            2'd1:    return mPresc;
            2'd2:    return mCount;
            default: return mCmp;
        endcase
    endfunction

    task automatic modelReset();
        mCount = 0; mCmp = 0; mPresc = 0; mPcnt = 0;
        mEn = 0; mAr = 0; mIe = 0; mMatch = 0; mOvf = 0; mTick = 0;
    endtask

    // Advance the model by one clock using the bus inputs present at that edge
    task automatic modelStep(input bit s, input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        bit fire, setM, setO;
        int unsigned oldCount;
        oldCount = mCount;
        fire = mEn && (mPcnt == mPresc);
        setM = 0;
        setO = 0;
        if (fire) begin
            if (mCount == mCmp) begin
                setM = 1;
                if (mAr) mCount = 0;
                else begin
                    setO = (mCount == 32'hFFFF_FFFF);
                    mCount = mCount + 1;
                end
            end else if (mCount == 32'hFFFF_FFFF) begin
                mCount = 0;
                setO = 1;
            end else begin
                mCount = mCount + 1;
            end
            mPcnt = 0;
        end else if (mEn) begin
            mPcnt = mPcnt + 1;
        end
        mTick = fire;
        if (s && w != 0) begin
            case (a)
                2'd0: begin
                    if (w[0]) begin mEn = d[0]; mAr = d[1]; mIe = d[2]; end
                    if (w[1]) begin
                        if (d[8]) mMatch = 0;
                        if (d[9]) mOvf = 0;
                    end
                end
                2'd1: begin
                    mPresc = byteMerge(mPresc, d, w) & 32'hFFFF;
                    mPcnt = 0;
                end
                2'd2: mCount = byteMerge(oldCount, d, w);
                default: mCmp = byteMerge(mCmp, d, w);
            endcase
        end
        if (setM) mMatch = 1;
        if (setO) mOvf = 1;
    endtask

    // Drive one bus cycle, check outputs mid-cycle, then advance the model at the edge
    task automatic applyStimulus(input bit s, input logic [1:0] a, input logic [3:0] w,
                                 input logic [3:0] r, input logic [31:0] d);
        int unsigned expR;
        @(negedge clk);
        sel = s; addr = a; we = w; re = r; wdata = d;
        #1;
        expR = (s && r != 0) ? modelRead(a) : 0;
        checkOutput("rdata", rdata, expR);
        checkOutput("irq", {31'd0, irq}, {31'd0, mIe && (mMatch || mOvf)});
        checkOutput("tick", {31'd0, tick}, {31'd0, mTick});
        lastRdata = rdata;
        lastIrq = irq;
        lastTick = tick;
        @(posedge clk);
        modelStep(s, a, w, d);
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
        applyStimulus(1'b1, a, w, 4'd0, d);
    endtask

    task automatic busRead(input logic [1:0] a);
        applyStimulus(1'b1, a, 4'd0, 4'b1111, 32'd0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 4'd0, 4'd0, 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        sel = 0; addr = 0; we = 0; re = 0; wdata = 0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int seen;
        int used;
        int unsigned seq[6];
        bit s;
        logic [1:0] a;
        logic [3:0] w, r;
        logic [31:0] d;

        modelReset();
        doReset();

        // Reset state: every register reads zero, outputs quiet
        for (int i = 0; i < 4; i++) begin
            busRead(i[1:0]);
            checkOutput("resetRead", lastRdata, 32'd0);
        end
        checkOutput("resetIrq", {31'd0, lastIrq}, 32'd0);
        checkOutput("resetTick", {31'd0, lastTick}, 32'd0);

        // Prescale 3, compare 5, enable only
        busWrite(2'd1, 32'd3, 4'b1111);
        busWrite(2'd3, 32'd5, 4'b1111);
        busWrite(2'd0, 32'h1, 4'b1111);
        seen = 0; used = 0;
        while (seen < 6 && used < 100) begin
            idle();
            used++;
            if (lastTick) seen++;
        end
        checkOutput("sixTicks", seen, 6);
        busRead(2'd2);
        checkOutput("countSix", lastRdata, 32'd6);
        busRead(2'd0);
        checkOutput("ctrlMatch", lastRdata, 32'h101);
        checkOutput("irqMasked", {31'd0, lastIrq}, 32'd0);

        // Prescale 0, compare 2, auto-reload with interrupts
        busWrite(2'd0, 32'h300, 4'b1111);
        busWrite(2'd2, 32'd0, 4'b1111);
        busWrite(2'd1, 32'd0, 4'b1111);
        busWrite(2'd3, 32'd2, 4'b1111);
        busWrite(2'd0, 32'h7, 4'b1111);
        seq = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            busRead(2'd2);
            checkOutput("reloadSeq", lastRdata, seq[i]);
        end
        checkOutput("irqAfterMatch", {31'd0, lastIrq}, 32'd1);
        busWrite(2'd0, 32'h107, 4'b0011);
        busRead(2'd0);
        checkOutput("matchCleared", lastRdata, 32'h7);
        idle();
        busRead(2'd0);
        checkOutput("matchReset", lastRdata, 32'h107);

        // Overflow from near the top of the range
        busWrite(2'd0, 32'h300, 4'b1111);
        busWrite(2'd2, 32'hFFFF_FFFE, 4'b1111);
        busWrite(2'd3, 32'd0, 4'b1111);
        busWrite(2'd1, 32'd0, 4'b1111);
        busWrite(2'd0, 32'h5, 4'b1111);
        busRead(2'd2);
        checkOutput("ovfPre1", lastRdata, 32'hFFFF_FFFE);
        busRead(2'd2);
        checkOutput("ovfPre2", lastRdata, 32'hFFFF_FFFF);
        busRead(2'd2);
        checkOutput("ovfWrap", lastRdata, 32'd0);
        checkOutput("ovfIrq", {31'd0, lastIrq}, 32'd1);
        busWrite(2'd0, 32'h200, 4'b0010);
        busRead(2'd0);
        checkOutput("ovfCleared", lastRdata, 32'h105);

        // Partial COUNT write colliding with a tick
        busWrite(2'd0, 32'h300, 4'b1111);
        busWrite(2'd2, 32'hAABB_CC00, 4'b1111);
        busWrite(2'd3, 32'd0, 4'b1111);
        busWrite(2'd1, 32'd0, 4'b1111);
        busWrite(2'd0, 32'h1, 4'b0001);
        busWrite(2'd2, 32'h0000_1234, 4'b0011);
        busRead(2'd2);
        checkOutput("partialWrite", lastRdata, 32'hAABB_1234);

        // Rewrite PRESCALE mid-period, then pause the timer
        busWrite(2'd0, 32'h300, 4'b1111);
        busWrite(2'd1, 32'd20, 4'b1111);
        busWrite(2'd2, 32'd0, 4'b1111);
        busWrite(2'd0, 32'h1, 4'b0001);
        for (int i = 0; i < 7; i++) idle();
        busWrite(2'd1, 32'd10, 4'b0011);
        used = 0;
        lastTick = 1'b0;
        while (!lastTick && used < 40) begin
            idle();
            used++;
        end
        // The 11th edge after the write raises tick, seen in the 12th sample
        checkOutput("prescRestart", used, 12);
        busWrite(2'd0, 32'h0, 4'b0001);
        for (int i = 0; i < 5; i++) idle();
        checkOutput("pausedTick", {31'd0, lastTick}, 32'd0);
        busRead(2'd2);
        checkOutput("pausedCount", lastRdata, 32'd1);

        // Randomized bus traffic with one asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset();
            s = ($urandom_range(0, 9) != 0);
            a = 2'($urandom_range(0, 3));
            r = 4'($urandom_range(0, 15));
            w = ($urandom_range(0, 99) < 70) ? 4'd0 : 4'($urandom_range(1, 15));
            case (a)
                2'd0: begin
                    d = $urandom;
                    d[0] = ($urandom_range(0, 3) != 0);
                end
                2'd1: d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
                default: d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 8))
                                                         : 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            applyStimulus(s, a, w, r, d);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
